// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// Same-cycle control outputs from state and inputs; a timed-out or abandoned memory wait locks into ERR.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_id_uses_rs1,
   input  logic             i_id_uses_rs2,
   input  logic [4:0]       i_ix_rd,
   input  logic             i_ix_mem_read,
   input  logic             i_ix_br_taken,
   input  logic             i_im_mem_req,
   input  logic             i_im_mem_ready,
   output logic             o_pc_stall,
   output logic             o_if_id_stall,
   output logic             o_id_ix_bubble,
   output logic             o_if_id_flush,
   output logic             o_id_ix_flush,
   output logic             o_id_ix_stall,
   output logic             o_ix_im_stall,
   output logic             o_im_iw_bubble,
   output logic             o_mem_err,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

   localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state, w_next_state;
   logic [15:0]      r_wait_cnt, w_next_wait_cnt;
   logic             r_mem_err;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_mem_stall, w_load_use, w_run, w_freeze;

   assign w_mem_stall = i_im_mem_req & ~i_im_mem_ready;
   assign w_load_use  = i_ix_mem_read & (i_ix_rd != 5'd0) &
                        ((i_id_uses_rs1 & (i_id_rs1 == i_ix_rd)) |
                         (i_id_uses_rs2 & (i_id_rs2 == i_ix_rd)));
   // While reset is held the outputs behave as if already back in RUN.
   assign w_run    = i_reset | (r_state == S_RUN);
   assign w_freeze = ~w_run | w_mem_stall;

   always_comb begin
      o_pc_stall     = 1'b0;
      o_if_id_stall  = 1'b0;
      o_id_ix_bubble = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ix_flush  = 1'b0;
      o_id_ix_stall  = 1'b0;
      o_ix_im_stall  = 1'b0;
      o_im_iw_bubble = 1'b0;
      if (w_freeze) begin
         o_pc_stall     = 1'b1;
         o_if_id_stall  = 1'b1;
         o_id_ix_stall  = 1'b1;
         o_ix_im_stall  = 1'b1;
         o_im_iw_bubble = 1'b1;
      end else if (i_ix_br_taken) begin
         o_if_id_flush = 1'b1;
         o_id_ix_flush = 1'b1;
      end else if (w_load_use) begin
         o_pc_stall     = 1'b1;
         o_if_id_stall  = 1'b1;
         o_id_ix_bubble = 1'b1;
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_next_wait_cnt = r_wait_cnt;
      case (r_state)
         S_RUN: begin
            if (w_mem_stall) begin
               w_next_state    = S_WAIT;
               w_next_wait_cnt = 16'd1;
            end
         end
         S_WAIT: begin
            // A request dropped without completion is treated like a timeout.
            if (i_im_mem_ready) begin
               w_next_state    = S_RUN;
               w_next_wait_cnt = 16'd0;
            end else if (!i_im_mem_req || (r_wait_cnt == TIMEOUT)) begin
               w_next_state = S_ERR;
            end else begin
               w_next_wait_cnt = r_wait_cnt + 16'd1;
            end
         end
         S_ERR:   w_next_state = S_ERR;
         default: w_next_state = S_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_RUN;
         r_wait_cnt  <= 16'd0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_wait_cnt;
         r_mem_err  <= r_mem_err | (w_next_state == S_ERR);
         if (o_pc_stall && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         if (o_if_id_flush && (r_flush_cnt != CNT_MAX))
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
   end

   assign o_mem_err   = r_mem_err;
   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with a cycle-level reference model
// Directed scenarios followed by randomized traffic; MEM_TIMEOUT=4 and CNT_W=4 exercise timeout and saturation.
module tb_hazard_ctrl;

   localparam int TO  = 4;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, br, req, rdy;
   } stim_t;

   typedef struct packed {
      logic [7:0]    ctl;
      logic          err;
      logic [CW-1:0] sc, fc;
   } exp_t;

   logic clk = 1'b0;
   logic reset, id_uses_rs1, id_uses_rs2, ix_mem_read, ix_br_taken, im_mem_req, im_mem_ready;
   logic [4:0] id_rs1, id_rs2, ix_rd;
   logic pc_stall, if_id_stall, id_ix_bubble, if_id_flush, id_ix_flush;
   logic id_ix_stall, ix_im_stall, im_iw_bubble, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
      .i_ix_rd(ix_rd), .i_ix_mem_read(ix_mem_read), .i_ix_br_taken(ix_br_taken),
      .i_im_mem_req(im_mem_req), .i_im_mem_ready(im_mem_ready),
      .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_id_ix_bubble(id_ix_bubble),
      .o_if_id_flush(if_id_flush), .o_id_ix_flush(id_ix_flush),
      .o_id_ix_stall(id_ix_stall), .o_ix_im_stall(ix_im_stall), .o_im_iw_bubble(im_iw_bubble),
      .o_mem_err(mem_err), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int    n_chk = 0;
   int    n_err = 0;
   exp_t  q[$];
   stim_t s;

   // Reference model: error flag, cycles spent waiting (0 = running), event totals.
   bit m_err  = 1'b0;
   int m_wait = 0;
   int m_stall = 0;
   int m_flush = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply();
      reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ix_rd = s.rd;
      id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ix_mem_read = s.mr;
      ix_br_taken = s.br; im_mem_req = s.req; im_mem_ready = s.rdy;
   endtask

   task automatic step();
      exp_t e;
      bit running, mstall, luse, frz;
      @(negedge clk);
      apply();
      running = s.rst || (!m_err && m_wait == 0);
      mstall  = s.req && !s.rdy;
      luse    = s.mr && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      frz     = !running || mstall;
      if (frz)       e.ctl = 8'b1100_0111;
      else if (s.br) e.ctl = 8'b0001_1000;
      else if (luse) e.ctl = 8'b1110_0000;
      else           e.ctl = 8'b0000_0000;
      e.err = m_err;
      e.sc  = CW'(m_stall);
      e.fc  = CW'(m_flush);
      q.push_back(e);
      if (s.rst) begin
         m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (e.ctl[7] && m_stall < CMAX) m_stall++;
         if (e.ctl[4] && m_flush < CMAX) m_flush++;
         if (m_err) begin
         end else if (m_wait == 0) begin
            if (mstall) m_wait = 1;
         end else if (s.rdy) begin
            m_wait = 0;
         end else if (!s.req || m_wait == TO) begin
            m_err = 1; m_wait = 0;
         end else begin
            m_wait++;
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("ctl", {24'd0, pc_stall, if_id_stall, id_ix_bubble, if_id_flush, id_ix_flush,
                     id_ix_stall, ix_im_stall, im_iw_bubble}, {24'd0, e.ctl});
         chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
         chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.sc});
         chk("flush_cnt", {28'd0, flush_cnt}, {28'd0, e.fc});
      end
   end

   initial begin
      s = '0; s.rst = 1'b1;
      @(negedge clk); apply();
      @(negedge clk);
      steps(2);
      s = '0;

      // load-use on rs2, then the same with rd=0
      s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
      step(); #2 chk("lu_stall", {31'd0, id_ix_bubble}, 32'd1);
      s = '0; step(); #2 chk("lu_cnt", {28'd0, stall_cnt}, 32'd1);
      s.mr = 1; s.rd = 0; s.rs1 = 0; s.rs2 = 0; s.u1 = 1; s.u2 = 1;
      step(); #2 chk("rd0_nostall", {31'd0, pc_stall}, 32'd0);

      // branch beats load-use; rs1==rs2 both hitting
      s = '0; s.mr = 1; s.rd = 7; s.rs1 = 7; s.rs2 = 7; s.u1 = 1; s.u2 = 1; s.br = 1;
      step(); #2 chk("br_over_lu", {31'd0, if_id_flush}, 32'd1);
      s.br = 0; steps(2);

      // memory wait 3 cycles, ready on 4th, branch held throughout
      s = '0; s.req = 1; s.br = 1;
      steps(3);
      s.rdy = 1; step();
      s.req = 0; s.rdy = 0; step(); #2 chk("br_after_freeze", {31'd0, if_id_flush}, 32'd1);
      s = '0; step();

      // timeout into ERR, sticky, then reset
      s.req = 1; steps(7);
      s = '0; steps(3); #2 chk("err_sticky", {31'd0, mem_err}, 32'd1);
      s.rst = 1; step();
      s.rst = 0; step(); #2 chk("err_cleared", {31'd0, mem_err}, 32'd0);

      // saturation: 20 stall cycles
      s.mr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1; steps(20);
      s = '0; step(); #2 chk("sat15", {28'd0, stall_cnt}, 32'd15);
      steps(2);

      // reset in the middle of a wait, abandoned request
      s.req = 1; steps(2);
      s.req = 0; s.rst = 1; step();
      s.rst = 0; step(); #2 chk("rst_in_wait", {31'd0, pc_stall}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         s.rst = ($urandom_range(0, 24) == 0);
         s.rs1 = 5'($urandom_range(0, 3));
         s.rs2 = 5'($urandom_range(0, 3));
         s.rd  = 5'($urandom_range(0, 3));
         s.u1  = 1'($urandom_range(0, 1));
         s.u2  = 1'($urandom_range(0, 1));
         s.mr  = 1'($urandom_range(0, 1));
         s.br  = ($urandom_range(0, 3) == 0);
         s.req = (m_wait != 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
         s.rdy = ($urandom_range(0, 2) == 0);
         step();
      end
      s = '0; steps(2);
      @(negedge clk); #4;
      chk("queue_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, max consecutive data-memory wait cycles before error (range 1..65535).
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ID_RS1, ID_RS2  in  5 each  source registers of instruction in ID.
REQ-006 ID_USES_RS1, ID_USES_RS2  in  1 each  ID instruction actually reads that source.
REQ-007 IX_RD  in  5  destination of instruction in IX; IX_MEM_READ  in  1  IX instruction is a load.
REQ-008 IX_BR_TAKEN  in  1  branch/jump resolved taken in IX this cycle.
REQ-009 IM_MEM_REQ  in  1  IM stage has a data-memory access; IM_MEM_READY  in  1  memory completes it this cycle.
REQ-010 PC_STALL, IF_ID_STALL  out  1 each  hold PC / IF-ID register.
REQ-011 ID_IX_BUBBLE  out  1  load NOP into ID-IX register.
REQ-012 IF_ID_FLUSH, ID_IX_FLUSH  out  1 each  squash IF-ID / ID-IX contents.
REQ-013 ID_IX_STALL, IX_IM_STALL  out  1 each  hold those registers; IM_IW_BUBBLE  out  1  load NOP into IM-IW.
REQ-014 MEM_ERR  out  1  sticky timeout flag.
REQ-015 STALL_CNT, FLUSH_CNT  out  CNT_W each  performance counters.

Function
REQ-016 FSM states RUN, WAIT, ERR; state, wait counter, counters and MEM_ERR are registers; all control outputs are combinational from current state and inputs (same-cycle).
REQ-017 mem_stall = IM_MEM_REQ & ~IM_MEM_READY.
REQ-018 load_use = IX_MEM_READ & (IX_RD != 0) & ((ID_USES_RS1 & ID_RS1 == IX_RD) | (ID_USES_RS2 & ID_RS2 == IX_RD)).
REQ-019 Freeze (RUN with mem_stall, any cycle in WAIT or ERR): PC_STALL, IF_ID_STALL, ID_IX_STALL, IX_IM_STALL, IM_IW_BUBBLE = 1; all flush and ID_IX_BUBBLE = 0.
REQ-020 Freeze has top priority; IX_BR_TAKEN and load_use are ignored during freeze and take effect in the first unfrozen cycle if still present.
REQ-021 RUN, no freeze, IX_BR_TAKEN=1: IF_ID_FLUSH=ID_IX_FLUSH=1, all stalls and ID_IX_BUBBLE=0 (branch overrides load_use).
REQ-022 RUN, no freeze, no branch, load_use=1: PC_STALL=IF_ID_STALL=ID_IX_BUBBLE=1, all others 0.
REQ-023 RUN otherwise: all control outputs 0.
REQ-024 RUN -> WAIT when mem_stall; wait counter loads 1.
REQ-025 WAIT: IM_MEM_READY=1 -> RUN (this cycle still frozen); else if wait counter == MEM_TIMEOUT -> ERR; else counter increments.
REQ-026 WAIT with IM_MEM_REQ dropped and READY low is a protocol error -> ERR.
REQ-027 ERR: MEM_ERR=1, freeze held, leaves only via reset.
REQ-028 STALL_CNT increments by 1 each cycle PC_STALL=1; FLUSH_CNT by 1 each cycle IF_ID_FLUSH=1; both saturate at all-ones and do not wrap.
REQ-029 IX_RD=0 never causes load_use; equal RS1 and RS2 both hitting counts as one stall.

Reset
REQ-030 reset=1 at a rising edge: state=RUN, wait counter=0, MEM_ERR=0, STALL_CNT=FLUSH_CNT=0, regardless of current state (including WAIT/ERR mid-operation).
REQ-031 While reset=1, control outputs follow REQ-016..023 evaluated in RUN; counters do not increment.

Verification
REQ-032 IX_MEM_READ=1, IX_RD=5, ID_RS2=5, ID_USES_RS2=1, one cycle -> PC_STALL=IF_ID_STALL=ID_IX_BUBBLE=1 that cycle, STALL_CNT=1 next cycle; same with IX_RD=0 -> no stall.
REQ-033 load_use and IX_BR_TAKEN same cycle -> IF_ID_FLUSH=ID_IX_FLUSH=1, PC_STALL=0, FLUSH_CNT+1, STALL_CNT unchanged.
REQ-034 IM_MEM_REQ=1, READY low 3 cycles then high -> freeze outputs 4 cycles, state back to RUN after, STALL_CNT+4; IX_BR_TAKEN held throughout -> flush in cycle 5.
REQ-035 MEM_TIMEOUT=4, READY never rises -> ERR after 4 WAIT cycles, MEM_ERR=1 sticky; reset -> MEM_ERR=0, RUN.
REQ-036 CNT_W=4, 20 stall cycles -> STALL_CNT=15, stays 15.
REQ-037 reset asserted during WAIT -> next cycle RUN, counters 0, no freeze with IM_MEM_REQ=0.
